// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
//   Bundles the requester streams and the FIFO write-port signals shared by
//   fifo_wr_arbiter and whatever drives it.
//
//   Parameters:
//     NREQ : number of requesters (>= 2)
//     DW   : data width per beat
//
//   Signals:
//     req_valid[NREQ]   per-requester beat valid
//     req_last[NREQ]    per-requester last beat of burst (qualified by req_valid)
//     req_data[NREQ*DW] requester i in bits [i*DW +: DW]
//     req_ready[NREQ]   per-requester beat accept
//     wfull, awfull     FIFO full / almost-full flags (registered in the FIFO)
//     winc, wdata       FIFO write strobe and data
//     grant_id          current or last granted requester
//     busy              a burst is in progress
//     burst_trunc       one-cycle pulse after a burst is released at MAXBURST
//
//   Modports:
//     slave  : the arbiter side
//     master : the requester/FIFO side that feeds the arbiter
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               wfull;
  logic               awfull;
  logic               winc;
  logic [DW-1:0]      wdata;
  logic [IW-1:0]      grant_id;
  logic               busy;
  logic               burst_trunc;

  modport slave (
    input  req_valid, req_last, req_data, wfull, awfull,
    output req_ready, winc, wdata, grant_id, busy, burst_trunc
  );

  modport master (
    output req_valid, req_last, req_data, wfull, awfull,
    input  req_ready, winc, wdata, grant_id, busy, burst_trunc
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter sharing one async-FIFO write port among NREQ
//   requesters in the wclk domain. A grant is held for a whole burst (closed
//   by req_last, or force-released after MAXBURST beats), so beats from
//   different requesters never interleave in the FIFO. One IDLE cycle
//   separates consecutive bursts.
//
//   Parameters:
//     NREQ     : number of requesters (>= 2)
//     DW       : data width per beat
//     MAXBURST : beats per grant before forced release (>= 1)
//
//   Ports:
//     wclk   : write-domain clock
//     wrst_n : asynchronous active-low reset
//     bus    : fifo_wr_arbiter_if.slave (requester streams, FIFO write port,
//              grant_id / busy / burst_trunc status)
//
//   Build option:
//     FIFO_ARB_AWFULL_STALL_EN : when defined, a new burst starts only while
//       both wfull and awfull are low, leaving at least two free slots at
//       burst start. When undefined, awfull is ignored. awfull never affects
//       a burst already in progress.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAXBURST = 16
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  // beat_cnt value before the beat that reaches MAXBURST
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NREQ - 1);

  logic [0:0]    state;
  logic [IW-1:0] grant_r;
  logic [IW-1:0] rr_last;
  logic [CW-1:0] beat_cnt;
  logic          trunc_r;

  logic          start_ok;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] scan_idx;
  logic          accept;
  logic          beat_last;
  logic [NREQ-1:0] ready_vec;
  logic [DW-1:0] wdata_mux;

`ifdef FIFO_ARB_AWFULL_STALL_EN
  assign start_ok = ~bus.wfull & ~bus.awfull;
`else
  assign start_ok = ~bus.wfull;
  logic unused_awfull;
  assign unused_awfull = bus.awfull;
`endif

  // Round-robin scan starting just after the last released requester; the
  // first valid requester found wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_last;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (scan_idx == IDX_MAX) ? '0 : scan_idx + IW'(1);
      if (!pick_found && bus.req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Data mux is driven regardless of winc; downstream only samples it with winc.
  always_comb begin
    wdata_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_r == IW'(i)) begin
        wdata_mux = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (state == LOCK && !bus.wfull) begin
      ready_vec[grant_r] = 1'b1;
    end
  end

  // wfull gates acceptance directly, so winc never fires while the FIFO is full.
  assign accept    = (state == LOCK) & bus.req_valid[grant_r] & ~bus.wfull;
  assign beat_last = bus.req_last[grant_r];

  assign bus.req_ready   = ready_vec;
  assign bus.winc        = accept;
  assign bus.wdata       = wdata_mux;
  assign bus.grant_id    = grant_r;
  assign bus.busy        = (state == LOCK);
  assign bus.burst_trunc = trunc_r;

  // ---- state register boundary ----
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      grant_r  <= '0;
      rr_last  <= IDX_MAX;
      beat_cnt <= '0;
      trunc_r  <= 1'b0;
    end else begin
      trunc_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found && start_ok) begin
            grant_r  <= pick_idx;
            beat_cnt <= '0;
            state    <= LOCK;
          end
        end
        default: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (beat_last) begin
              state   <= IDLE;
              rr_last <= grant_r;
            end else if (beat_cnt == CNT_LAST) begin
              // Forced release: the rest of this requester's data competes
              // again as a fresh burst.
              state   <= IDLE;
              rr_last <= grant_r;
              trunc_r <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter. Each requester owns a queue of
//   beats; a transaction-level reference model (owner, round-robin pointer,
//   beat count) predicts the DUT outputs every cycle. Scenario tasks add
//   their own end-of-scenario checks on observed grants and write counts.
module tb_fifo_wr_arbiter;

  localparam int NREQ     = 4;
  localparam int DW       = 8;
  localparam int MAXBURST = 16;
  localparam int IW       = $clog2(NREQ);
  localparam int QD       = 64;

`ifdef FIFO_ARB_AWFULL_STALL_EN
  localparam logic AF_GATE = 1'b1;
`else
  localparam logic AF_GATE = 1'b0;
`endif

  logic wclk   = 1'b0;
  logic wrst_n = 1'b1;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(MAXBURST)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Requester beat queues, flat storage: requester r slot s at r*QD + s.
  logic [DW-1:0] qd[$];
  logic          ql[$];
  int            qh[$];
  int            qt[$];

  // Reference model
  int   m_owner;
  int   m_rr;
  int   m_grant;
  int   m_cnt;
  logic m_trunc;

  int bubble_pct;
  int full_pct;
  int afull_pct;

  int   obs_busy;
  int   obs_winc;
  int   obs_trunc;
  logic prev_busy;
  int   dut_gnt[$];

  function automatic int q_pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += qt[i] - qh[i];
    return s;
  endfunction

  task automatic q_clear();
    if (qd.size() == 0) begin
      for (int i = 0; i < NREQ * QD; i++) begin
        qd.push_back('0);
        ql.push_back(1'b0);
      end
    end
    qh.delete();
    qt.delete();
    for (int i = 0; i < NREQ; i++) begin
      qh.push_back(0);
      qt.push_back(0);
    end
  endtask

  task automatic push_burst(input int r, input int len);
    for (int b = 0; b < len; b++) begin
      qd[r*QD + qt[r]] = DW'($urandom);
      ql[r*QD + qt[r]] = (b == len - 1);
      qt[r] = qt[r] + 1;
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = NREQ - 1;
    m_grant = 0;
    m_cnt   = 0;
    m_trunc = 1'b0;
  endtask

  task automatic obs_clear();
    obs_busy  = 0;
    obs_winc  = 0;
    obs_trunc = 0;
    prev_busy = 1'b0;
    dut_gnt.delete();
  endtask

  task automatic drive_idle();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
    bus.awfull    = 1'b0;
  endtask

  // Called at a falling edge; leaves the bench at the next falling edge.
  task automatic do_reset();
    wrst_n = 1'b0;
    drive_idle();
    bubble_pct = 0;
    full_pct   = 0;
    afull_pct  = 0;
    q_clear();
    model_reset();
    obs_clear();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    logic [NREQ-1:0]    v, l, t, exp_ready;
    logic [NREQ*DW-1:0] d;
    logic               exp_busy, exp_winc, start_ok;
    logic [DW-1:0]      exp_wdata;
    logic [IW-1:0]      exp_gid;
    int                 idx;

    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (qh[i] != qt[i]) begin
        if ($urandom_range(99) >= bubble_pct) v |= NREQ'(1) << i;
        if (ql[i*QD + qh[i]]) l |= NREQ'(1) << i;
        d |= (NREQ*DW)'(qd[i*QD + qh[i]]) << (i*DW);
      end
    end
    if (full_pct > 0)  bus.wfull  = ($urandom_range(99) < full_pct);
    if (afull_pct > 0) bus.awfull = ($urandom_range(99) < afull_pct);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    #1;

    exp_busy  = (m_owner >= 0);
    exp_ready = '0;
    exp_winc  = 1'b0;
    exp_wdata = '0;
    if (exp_busy) begin
      t = v >> m_owner;
      if (!bus.wfull) exp_ready = NREQ'(1) << m_owner;
      exp_winc  = t[0] && !bus.wfull;
      exp_wdata = qd[m_owner*QD + qh[m_owner]];
    end
    exp_gid = IW'(m_grant);

    n_tests++;
    if (bus.busy !== exp_busy) begin
      n_fail++;
      $display("FAIL cyc%0d busy: got %b want %b", cyc, bus.busy, exp_busy);
    end
    n_tests++;
    if (bus.req_ready !== exp_ready) begin
      n_fail++;
      $display("FAIL cyc%0d req_ready: got %b want %b", cyc, bus.req_ready, exp_ready);
    end
    n_tests++;
    if (bus.winc !== exp_winc) begin
      n_fail++;
      $display("FAIL cyc%0d winc: got %b want %b", cyc, bus.winc, exp_winc);
    end
    if (exp_winc) begin
      n_tests++;
      if (bus.wdata !== exp_wdata) begin
        n_fail++;
        $display("FAIL cyc%0d wdata: got %h want %h", cyc, bus.wdata, exp_wdata);
      end
    end
    n_tests++;
    if (bus.grant_id !== exp_gid) begin
      n_fail++;
      $display("FAIL cyc%0d grant_id: got %0d want %0d", cyc, bus.grant_id, exp_gid);
    end
    n_tests++;
    if (bus.burst_trunc !== m_trunc) begin
      n_fail++;
      $display("FAIL cyc%0d burst_trunc: got %b want %b", cyc, bus.burst_trunc, m_trunc);
    end

    if (bus.busy === 1'b1 && prev_busy !== 1'b1) dut_gnt.push_back(int'(bus.grant_id));
    prev_busy = bus.busy;
    if (bus.busy === 1'b1)        obs_busy++;
    if (bus.winc === 1'b1)        obs_winc++;
    if (bus.burst_trunc === 1'b1) obs_trunc++;

    m_trunc = 1'b0;
    if (m_owner < 0) begin
      start_ok = !bus.wfull;
      if (AF_GATE) start_ok = start_ok && !bus.awfull;
      if (start_ok && v != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_rr + k) % NREQ;
          t   = v >> idx;
          if (m_owner < 0 && t[0]) m_owner = idx;
        end
        m_grant = m_owner;
        m_cnt   = 0;
      end
    end else if (exp_winc) begin
      t = l >> m_owner;
      qh[m_owner] = qh[m_owner] + 1;
      m_cnt++;
      if (t[0]) begin
        m_rr    = m_owner;
        m_owner = -1;
      end else if (m_cnt == MAXBURST) begin
        m_rr    = m_owner;
        m_owner = -1;
        m_trunc = 1'b1;
      end
    end

    cyc++;
    @(posedge wclk);
    @(negedge wclk);
  endtask

  task automatic run_until_done(input int bound, input string tag);
    int c = 0;
    while ((q_pending() > 0 || m_owner >= 0) && c < bound) begin
      step();
      c++;
    end
    if (q_pending() > 0 || m_owner >= 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: %0d beats pending after %0d cycles, want 0", tag, q_pending(), bound);
    end
    step();
  endtask

  task automatic test_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    drive_idle();
    bus.req_valid = '1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    n_tests++;
    if (bus.winc !== 1'b0) begin n_fail++; $display("FAIL reset winc: got %b want 0", bus.winc); end
    n_tests++;
    if (bus.req_ready !== '0) begin n_fail++; $display("FAIL reset req_ready: got %b want 0", bus.req_ready); end
    n_tests++;
    if (bus.grant_id !== '0) begin n_fail++; $display("FAIL reset grant_id: got %0d want 0", bus.grant_id); end
    n_tests++;
    if (bus.burst_trunc !== 1'b0) begin n_fail++; $display("FAIL reset burst_trunc: got %b want 0", bus.burst_trunc); end
    @(negedge wclk);
    do_reset();
  endtask

  task automatic test_round_robin();
    int exp_g[$] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int r = 0; r < NREQ; r++) push_burst(r, 2);
    push_burst(0, 2);
    run_until_done(200, "rr");
    n_tests++;
    if (dut_gnt.size() != exp_g.size()) begin
      n_fail++;
      $display("FAIL rr grant count: got %0d want %0d", dut_gnt.size(), exp_g.size());
    end else begin
      for (int k = 0; k < exp_g.size(); k++) begin
        n_tests++;
        if (dut_gnt[k] != exp_g[k]) begin
          n_fail++;
          $display("FAIL rr grant[%0d]: got %0d want %0d", k, dut_gnt[k], exp_g[k]);
        end
      end
    end
    n_tests++;
    if (obs_winc != 10) begin n_fail++; $display("FAIL rr writes: got %0d want 10", obs_winc); end
    n_tests++;
    if (obs_busy != 10) begin n_fail++; $display("FAIL rr busy cycles: got %0d want 10", obs_busy); end
  endtask

  task automatic test_single();
    do_reset();
    push_burst(2, 5);
    run_until_done(50, "single");
    n_tests++;
    if (dut_gnt.size() != 1 || dut_gnt[0] != 2) begin
      n_fail++;
      $display("FAIL single grant: got %0d grants first %0d want 1 grant of 2", dut_gnt.size(),
               (dut_gnt.size() > 0) ? dut_gnt[0] : -1);
    end
    n_tests++;
    if (obs_busy != 5) begin n_fail++; $display("FAIL single busy cycles: got %0d want 5", obs_busy); end
    n_tests++;
    if (obs_winc != 5) begin n_fail++; $display("FAIL single writes: got %0d want 5", obs_winc); end
    n_tests++;
    if (obs_trunc != 0) begin n_fail++; $display("FAIL single trunc pulses: got %0d want 0", obs_trunc); end
  endtask

  task automatic test_full_stall();
    do_reset();
    push_burst(0, 4);
    push_burst(1, 2);
    for (int c = 0; c < 4; c++) begin
      bus.wfull = (c == 2 || c == 3);
      step();
    end
    n_tests++;
    if (obs_winc != 1) begin n_fail++; $display("FAIL stall writes during full: got %0d want 1", obs_winc); end
    bus.wfull = 1'b0;
    run_until_done(50, "stall");
    n_tests++;
    if (dut_gnt.size() != 2 || dut_gnt[0] != 0 || dut_gnt[1] != 1) begin
      n_fail++;
      $display("FAIL stall grants: got %0d grants want order 0,1", dut_gnt.size());
    end
    n_tests++;
    if (obs_winc != 6) begin n_fail++; $display("FAIL stall writes: got %0d want 6", obs_winc); end
    n_tests++;
    if (obs_busy != 8) begin n_fail++; $display("FAIL stall busy cycles: got %0d want 8", obs_busy); end
  endtask

  task automatic test_maxburst();
    do_reset();
    push_burst(1, 20);
    run_until_done(100, "maxburst");
    n_tests++;
    if (dut_gnt.size() != 2 || dut_gnt[0] != 1 || dut_gnt[1] != 1) begin
      n_fail++;
      $display("FAIL maxburst grants: got %0d grants want 1,1", dut_gnt.size());
    end
    n_tests++;
    if (obs_trunc != 1) begin n_fail++; $display("FAIL maxburst trunc pulses: got %0d want 1", obs_trunc); end
    n_tests++;
    if (obs_winc != 20) begin n_fail++; $display("FAIL maxburst writes: got %0d want 20", obs_winc); end
    n_tests++;
    if (obs_busy != 20) begin n_fail++; $display("FAIL maxburst busy cycles: got %0d want 20", obs_busy); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_burst(0, 6);
    repeat (3) step();
    bus.req_valid = 4'b0001;
    bus.req_last  = '0;
    #1;
    n_tests++;
    if (bus.winc !== 1'b1) begin n_fail++; $display("FAIL midrst beat3 winc: got %b want 1", bus.winc); end
    wrst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.winc !== 1'b0) begin n_fail++; $display("FAIL midrst winc: got %b want 0", bus.winc); end
    n_tests++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
    n_tests++;
    if (bus.req_ready !== '0) begin n_fail++; $display("FAIL midrst req_ready: got %b want 0", bus.req_ready); end
    drive_idle();
    @(negedge wclk);
    wrst_n = 1'b1;
    q_clear();
    model_reset();
    obs_clear();
    push_burst(2, 2);
    push_burst(0, 2);
    run_until_done(50, "midrst");
    n_tests++;
    if (dut_gnt.size() != 2 || dut_gnt[0] != 0 || dut_gnt[1] != 2) begin
      n_fail++;
      $display("FAIL midrst grants after release: got %0d grants first %0d want 0 then 2", dut_gnt.size(),
               (dut_gnt.size() > 0) ? dut_gnt[0] : -1);
    end
  endtask

  task automatic test_awfull();
    do_reset();
    bus.awfull = 1'b1;
    push_burst(3, 3);
    step();
    n_tests++;
    if (bus.busy !== !AF_GATE) begin
      n_fail++;
      $display("FAIL awfull busy after 1 cycle: got %b want %b", bus.busy, !AF_GATE);
    end
    if (AF_GATE) begin
      repeat (3) step();
      n_tests++;
      if (obs_busy != 0) begin n_fail++; $display("FAIL awfull held grant: got %0d busy cycles want 0", obs_busy); end
      bus.awfull = 1'b0;
      step();
      bus.awfull = 1'b1;
    end
    run_until_done(50, "awfull");
    n_tests++;
    if (obs_winc != 3) begin n_fail++; $display("FAIL awfull writes: got %0d want 3", obs_winc); end
    n_tests++;
    if (dut_gnt.size() != 1 || dut_gnt[0] != 3) begin
      n_fail++;
      $display("FAIL awfull grants: got %0d grants want one grant of 3", dut_gnt.size());
    end
    bus.awfull = 1'b0;
  endtask

  task automatic test_random();
    int total;
    repeat (3) begin
      do_reset();
      bubble_pct = 25;
      full_pct   = 15;
      afull_pct  = 30;
      total      = 0;
      for (int r = 0; r < NREQ; r++) begin
        int nb = $urandom_range(1, 2);
        for (int b = 0; b < nb; b++) begin
          int len = $urandom_range(1, 20);
          push_burst(r, len);
          total += len;
        end
      end
      run_until_done(3000, "random");
      n_tests++;
      if (obs_winc != total) begin n_fail++; $display("FAIL random writes: got %0d want %0d", obs_winc, total); end
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    q_clear();
    obs_clear();
    bubble_pct = 0;
    full_pct   = 0;
    afull_pct  = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_full_stall();
    test_maxburst();
    test_mid_reset();
    test_awfull();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin burst arbiter sharing one async-FIFO write port among `NREQ` requesters in the `wclk` domain. It sits between the requester streams and the FIFO write-pointer/full logic. It consumes the FIFO's registered `wfull`/`awfull` flags and drives `winc`/`wdata`. A grant is held for a whole burst, closed by `req_last`, so beats from different requesters never interleave in the FIFO.

## Interface
- `NREQ`, 4: number of requesters; must be ≥2.
- `DW`, 8: data width per beat.
- `MAXBURST`, 16: maximum beats per grant before forced release; must be ≥1.
- `IW`, `$clog2(NREQ)`: grant-index width (derived).

Ports:
- `wclk` in 1: write-domain clock.
- `wrst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: per-requester beat valid.
- `req_last` in NREQ: per-requester last beat of burst, qualified by `req_valid`.
- `req_data` in NREQ*DW: requester i occupies bits [i*DW +: DW].
- `req_ready` out NREQ: beat accepted when `req_valid[i] & req_ready[i]`.
- `wfull` in 1: FIFO full, registered in FIFO.
- `awfull` in 1: FIFO almost full, one slot left.
- `winc` out 1: FIFO write strobe.
- `wdata` out DW: FIFO write data.
- `grant_id` out IW: index of the current or last granted requester.
- `busy` out 1: a burst is in progress (state LOCK).
- `burst_trunc` out 1: one-cycle pulse when a burst is force-released at `MAXBURST`.

## Operation
- FSM has 2 states: IDLE and LOCK. Registers: `state`, `grant_id`, `rr_last` (IW), `beat_cnt` ($clog2(MAXBURST+1) bits), `burst_trunc`.
- **IDLE:** `req_ready`=0, `winc`=0.
  - If any `req_valid` is set and the start is permitted, select the first set requester scanning `rr_last+1`, `rr_last+2`, … modulo NREQ.
  - Register its index in `grant_id`, clear `beat_cnt`, and go to LOCK.
  - The start is permitted when `wfull`=0, plus the gating in Configuration.
- **LOCK:**
  - `req_ready[grant_id]` = ~`wfull`; all other `req_ready` bits are 0.
  - `winc` = `req_valid[grant_id]` & ~`wfull`.
  - `wdata` = `req_data[grant_id]`, combinational mux, valid whenever `winc`=1.
  - Each accepted beat increments `beat_cnt`.
  - Accepted beat with `req_last`=1 → next state IDLE, `rr_last`←`grant_id`.
  - Accepted beat without `req_last` that makes `beat_cnt`=MAXBURST → next state IDLE, `rr_last`←`grant_id`, `burst_trunc` pulses next cycle. That requester's remaining beats re-arbitrate as a new burst.
- `wdata` is don't-care when `winc`=0; the implementation drives the muxed value regardless.
- `req_valid` dropping mid-burst: grant is held, no write, no timeout (bubble).
- `wfull` mid-burst: `req_ready`=0 and grant held until `wfull` clears. The FIFO also gates `winc` on `wfull`; this block never asserts `winc` while `wfull`=1.
- Requesters other than `grant_id` raising `req_valid` in LOCK have no effect until IDLE.
- `req_last` is sampled only on accepted beats.

## Timing
- Reset values (asynchronous on `wrst_n` low):
  - state IDLE, `grant_id`=0, `rr_last`=NREQ-1 (requester 0 has first priority), `beat_cnt`=0, `burst_trunc`=0.
  - Consequently `busy`=0, `winc`=0, `req_ready`=0.
- Reset mid-burst: outputs drop in the same instant; the partial burst is abandoned; FIFO contents are untouched.
- Arbitration latency: 1 cycle. A requester valid at edge N (IDLE) sees `req_ready` during cycle N+1.
- Throughput:
  - 1 beat/cycle within a burst.
  - 1 dead cycle (IDLE) between bursts.
  - A burst of L beats with no stall occupies L+1 cycles.
- `busy` = (state==LOCK), registered.
- `burst_trunc` is a registered pulse exactly one cycle wide, asserted in the first IDLE cycle after release.
- `wfull` is sampled combinationally each cycle. Because the FIFO registers `wfull` from the post-write pointer, `winc` gated by the current `wfull` never overruns.

## Configuration
- `FIFO_ARB_AWFULL_STALL_EN` defined: a new burst is started only when `wfull`=0 AND `awfull`=0. This guarantees ≥2 free slots at burst start. `awfull` has no effect inside LOCK.
- `FIFO_ARB_AWFULL_STALL_EN` undefined: the `awfull` input is ignored; a burst starts whenever `wfull`=0.

## Test plan
- **Reset:** all `req_valid` high → grant order 0,1,2,3,0. Each 2-beat burst yields 2 `winc` pulses carrying that requester's data, with 1 idle cycle between bursts.
- **Single requester:** requester 2 sends 5 beats, last on beat 5 → `grant_id`=2, `busy` for 5 cycles, 5 writes in order, `burst_trunc`=0.
- **Full stall:** `wfull` forced high on beats 2–3 of a 4-beat burst → `req_ready`=0 and `winc`=0 for those cycles. Beats resume with no loss or duplication, and no other requester is granted.
- **MAXBURST=16:** requester 1 sends 20 beats without `req_last` → 16 writes, `burst_trunc` pulse, then requester 1 is re-granted for the remaining 4 beats, if it is the only one valid.
- **Mid-burst reset:** `wrst_n` low during beat 3 → `winc`/`busy`/`req_ready` are 0 immediately. After release, requester 0 is granted first.
- **Almost-full gating:** `awfull`=1, `wfull`=0, requester 3 valid in IDLE:
  - macro defined → no grant until `awfull`=0.
  - macro undefined → grant next cycle.
